vector_inst_dispatcher: RTL and testbench
=========================================

# vector_inst_dispatcher

Scalar-side issue unit for the vector co-processor. It accepts vector instructions and their rs1/rs2 operands from the scalar pipeline into a small FIFO, and presents them one at a time on the `inst_valid`/`vec_pro_ready` handshake. It then drives `scalar_pro_ready` and waits for `vec_pro_ack`, and returns a one-cycle completion response carrying the captured `csr_out` value plus illegal and timeout flags. It sits between the scalar core's execute stage and the top-level `vector_processor` ports.

## Interface
- `DEPTH`, 2: pending-instruction FIFO entries (≥1).
- `TIMEOUT`, 1024: maximum cycles from entering SEND to ack before the instruction is abandoned (≥2).
- Data width is `XLEN` from `vector_processor_defs.svh` (32).
- Reset: one clock; reset is asynchronous and active-low. `reset` low clears all state immediately.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: async active-low reset.
- `req_valid` in 1: scalar pipeline offers an instruction.
- `req_ready` out 1: FIFO can accept; equals `!full`.
- `req_instruction` in XLEN: instruction word.
- `req_rs1_data` in XLEN: rs1 operand.
- `req_rs2_data` in XLEN: rs2 operand.
- `inst_valid` out 1: issued instruction valid to the vector processor.
- `instruction` out XLEN: issued instruction.
- `rs1_data` out XLEN: issued rs1 operand.
- `rs2_data` out XLEN: issued rs2 operand.
- `vec_pro_ready` in 1: vector processor ready to take an instruction.
- `is_vec` in 1: vector decode reports a legal vector instruction.
- `scalar_pro_ready` out 1: dispatcher ready to take completion.
- `vec_pro_ack` in 1: vector processor finished the instruction.
- `csr_out` in XLEN: CSR read data (vl for vset*).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out XLEN: `csr_out` captured at ack; 0 on illegal or timeout.
- `resp_illegal` out 1: qualifies `resp_valid`; `is_vec` was 0.
- `resp_timeout` out 1: qualifies `resp_valid`; `TIMEOUT` expired.
- `busy` out 1: high whenever the state is not IDLE or the FIFO is non-empty.

## Operation
- **FIFO.** Circular buffer with write and read pointers of width `$clog2(DEPTH)` that wrap at `DEPTH-1`, and `count` of width `$clog2(DEPTH+1)`. Push on `req_valid && req_ready`. Pop only from IDLE.
  - When full, `req_ready`=0 even in a pop cycle.
  - A simultaneous push and pop leaves `count` unchanged.
- **FSM states:** IDLE, SEND, CHECK, WAIT_ACK, RESP.
- **IDLE:**
  - If FIFO is non-empty: pop the head into the `instruction`/`rs1_data`/`rs2_data` registers, set `inst_valid`<=1, clear the timer, go to SEND.
  - Otherwise stay in IDLE.
- **SEND:** `inst_valid`=1 and the outputs are held stable.
  - The transfer happens on the cycle with `inst_valid && vec_pro_ready`. Then `inst_valid`<=0 and the state goes to CHECK.
  - `vec_pro_ready` may already be high on the cycle `inst_valid` rises; the transfer then happens in that cycle.
- **CHECK:** one cycle. Sample `is_vec`.
  - 0: go to RESP with illegal set.
  - 1: go to WAIT_ACK.
- **WAIT_ACK:** `scalar_pro_ready`=1. On `vec_pro_ack`: capture `csr_out` into `resp_data` and go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle with its flags, then go to IDLE. There is no backpressure.
- **Timer:** counts in SEND and WAIT_ACK. At `TIMEOUT-1` without a transfer or ack:
  - drop `inst_valid`;
  - set `resp_timeout`, with `resp_data`=0;
  - go to RESP.
  - A transfer or ack on the expiry cycle wins over the timeout.
- A `vec_pro_ack` seen outside WAIT_ACK is ignored.

## Timing
- **Reset values:** every output is 0 except `req_ready`=1. State IDLE, FIFO empty, timer 0.
- **Reset mid-operation:** the in-flight instruction and FIFO contents are discarded, no response is issued, and outputs return to reset values asynchronously.
- **Issue latency:** a request accepted in cycle N is written to the FIFO at the end of N. IDLE pops in N+1, and `inst_valid` is high in N+2.
- **Best-case turnaround** (ready already high, ack one cycle after CHECK): the transfer is in N+2, CHECK in N+3, ack in N+4, and `resp_valid` in N+5.
- **Issue rate:** back-to-back instructions are separated by at least RESP→IDLE→SEND, i.e. 2 cycles after `resp_valid`.
- **Register updates:**
  - `resp_*` flags and `resp_data` are registered and valid only while `resp_valid`=1. They clear to 0 the following cycle.
  - `instruction`/`rs*_data` retain their last value after transfer.
- **FIFO wrap:** the `DEPTH`-th push wraps the write pointer to 0 with no loss or duplication.

## Test plan
- **Single vset:** push `req_instruction`=32'h0C0572D7, rs1=32'd100. Hold `vec_pro_ready`=1 and `is_vec`=1, with ack 2 cycles after CHECK and `csr_out`=32'd8. Required: `inst_valid` high in N+2, `resp_valid` once with `resp_data`=8 and both flags 0.
- **Delayed ready:** `vec_pro_ready` low for 5 cycles. Required: `inst_valid` and the instruction are held stable all 5 cycles, and the transfer happens on cycle 6.
- **Illegal:** `is_vec`=0 in CHECK. Required: `resp_illegal`=1, `resp_data`=0, `scalar_pro_ready` never asserted.
- **Full FIFO:** with `DEPTH`=2, push 3 instructions (A, B, C) while `vec_pro_ready`=0. Required:
  - A is issued and B, C fill the FIFO, so `req_ready`=0 after C.
  - Completions arrive in order A, B, C.
  - The write pointer wraps correctly.
- **Timeout:** with `TIMEOUT`=16, never assert `vec_pro_ack`. Required: `resp_timeout`=1 exactly 16 cycles after entering SEND, and the next instruction is issued afterward.
- **Reset mid-operation:** assert `reset` low in WAIT_ACK with 1 entry queued. Required: all outputs return to reset values immediately, and no `resp_valid` is seen after release.

Source files
------------

// File: rtl/vector_inst_dispatcher_if.sv
// Bundle of the scalar-request, vector-issue and completion signals around the
// vector instruction dispatcher. The master modport is the dispatcher itself;
// the slave modport is its environment (scalar pipeline plus vector processor).
interface vector_inst_dispatcher_if #(
  parameter int unsigned XLEN = 32
);
  // Scalar pipeline request side
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_instruction;
  logic [XLEN-1:0] req_rs1_data;
  logic [XLEN-1:0] req_rs2_data;

  // Issue towards the vector processor
  logic            inst_valid;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            vec_pro_ready;
  logic            is_vec;
  logic            scalar_pro_ready;
  logic            vec_pro_ack;
  logic [XLEN-1:0] csr_out;

  // Completion back to the scalar pipeline
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            resp_illegal;
  logic            resp_timeout;
  logic            busy;

  modport master (
    input  req_valid, req_instruction, req_rs1_data, req_rs2_data,
    input  vec_pro_ready, is_vec, vec_pro_ack, csr_out,
    output req_ready, inst_valid, instruction, rs1_data, rs2_data,
    output scalar_pro_ready, resp_valid, resp_data, resp_illegal, resp_timeout, busy
  );

  modport slave (
    output req_valid, req_instruction, req_rs1_data, req_rs2_data,
    output vec_pro_ready, is_vec, vec_pro_ack, csr_out,
    input  req_ready, inst_valid, instruction, rs1_data, rs2_data,
    input  scalar_pro_ready, resp_valid, resp_data, resp_illegal, resp_timeout, busy
  );
endinterface

// File: rtl/vector_inst_dispatcher.sv
// Scalar-side issue unit: queues vector instructions with their operands, issues
// them one at a time to the vector processor, waits for completion and returns a
// single-cycle response (CSR data, illegal flag, timeout flag).
module vector_inst_dispatcher #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned XLEN    = 32
) (
  input logic                      clk,
  input logic                      reset,
  vector_inst_dispatcher_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSend, StCheck, StWaitAck, StResp} state_e;

  state_e          state_q;
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_rs1  [DEPTH];
  logic [XLEN-1:0] mem_rs2  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [TmrW-1:0] timer_q;

  logic            inst_valid_q;
  logic            scalar_ready_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_illegal_q;
  logic            resp_timeout_q;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            timer_done;
  logic [TmrW-1:0] timer_next;

  // Full blocks a push even when the same cycle pops.
  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign push       = bus.req_valid && !full;
  assign pop        = (state_q == StIdle) && !empty;
  assign timer_done = (timer_q == TmrLast);
  // Saturate so a transfer on the expiry cycle cannot wrap the budget back to zero.
  assign timer_next = timer_done ? timer_q : timer_q + 1'b1;

  // FIFO storage: write the incoming request at the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_rs1[i]  <= '0;
        mem_rs2[i]  <= '0;
      end
    end else if (push) begin
      mem_inst[wr_ptr_q] <= bus.req_instruction;
      mem_rs1[wr_ptr_q]  <= bus.req_rs1_data;
      mem_rs2[wr_ptr_q]  <= bus.req_rs2_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Issue/completion FSM with registered outputs and the SEND/WAIT_ACK timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      inst_valid_q   <= 1'b0;
      scalar_ready_q <= 1'b0;
      inst_q         <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_illegal_q <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            inst_q       <= mem_inst[rd_ptr_q];
            rs1_q        <= mem_rs1[rd_ptr_q];
            rs2_q        <= mem_rs2[rd_ptr_q];
            inst_valid_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= StSend;
          end
        end
        StSend: begin
          timer_q <= timer_next;
          if (bus.vec_pro_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= StCheck;
          end else if (timer_done) begin
            inst_valid_q   <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
            resp_data_q    <= '0;
            state_q        <= StResp;
          end
        end
        StCheck: begin
          if (bus.is_vec) begin
            scalar_ready_q <= 1'b1;
            state_q        <= StWaitAck;
          end else begin
            resp_valid_q   <= 1'b1;
            resp_illegal_q <= 1'b1;
            resp_data_q    <= '0;
            state_q        <= StResp;
          end
        end
        StWaitAck: begin
          timer_q <= timer_next;
          if (bus.vec_pro_ack) begin
            scalar_ready_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_data_q    <= bus.csr_out;
            state_q        <= StResp;
          end else if (timer_done) begin
            scalar_ready_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
            resp_data_q    <= '0;
            state_q        <= StResp;
          end
        end
        StResp: begin
          resp_valid_q   <= 1'b0;
          resp_data_q    <= '0;
          resp_illegal_q <= 1'b0;
          resp_timeout_q <= 1'b0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready        = !full;
  assign bus.inst_valid       = inst_valid_q;
  assign bus.instruction      = inst_q;
  assign bus.rs1_data         = rs1_q;
  assign bus.rs2_data         = rs2_q;
  assign bus.scalar_pro_ready = scalar_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_data        = resp_data_q;
  assign bus.resp_illegal     = resp_illegal_q;
  assign bus.resp_timeout     = resp_timeout_q;
  assign bus.busy             = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_vector_inst_dispatcher.sv
// Bench for vector_inst_dispatcher: directed scenarios with hand-computed cycle
// expectations, plus a queue-level model checked on every negedge.
module tb_vector_inst_dispatcher;

  localparam int Depth   = 2;
  localparam int Timeout = 16;
  localparam logic [31:0] AckMask = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        illegal;
    logic        timeout;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vector_inst_dispatcher_if #(.XLEN(32)) bus ();

  vector_inst_dispatcher #(
    .DEPTH  (Depth),
    .TIMEOUT(Timeout),
    .XLEN   (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit auto_ack = 1'b0;

  // Model state: pending queue, in-flight instruction, expected responses.
  req_t  pend[$];
  resp_t exp_q[$];
  req_t  cur;
  bit    have_cur = 1'b0;
  bit    engine_free = 1'b1;
  bit    release_next = 1'b0;
  bit    issued_now = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [31:0] data, input logic ill, input logic tmo);
    resp_t r;
    r.data    = data;
    r.illegal = ill;
    r.timeout = tmo;
    exp_q.push_back(r);
  endtask

  // Step into the next cycle; inputs change 1 time unit after the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      bus.vec_pro_ack = bus.scalar_pro_ready;
      bus.csr_out     = bus.instruction ^ AckMask;
    end
  endtask

  task automatic push_req(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.req_valid       = 1'b1;
    bus.req_instruction = inst;
    bus.req_rs1_data    = rs1;
    bus.req_rs2_data    = rs2;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check32(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Model: an idle engine takes the queue head; a full queue refuses pushes.
  always @(posedge clk) begin
    if (reset) begin : model_step
      int cnt_before;
      cnt_before = pend.size();
      issued_now = 1'b0;
      if (engine_free && cnt_before != 0) begin
        cur         = pend.pop_front();
        have_cur    = 1'b1;
        engine_free = 1'b0;
        issued_now  = 1'b1;
      end
      if (release_next) begin
        engine_free  = 1'b1;
        release_next = 1'b0;
      end
      if (bus.req_valid && cnt_before < Depth) begin
        pend.push_back({bus.req_instruction, bus.req_rs1_data, bus.req_rs2_data});
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      pend.delete();
      exp_q.delete();
      have_cur     = 1'b0;
      engine_free  = 1'b1;
      release_next = 1'b0;
      issued_now   = 1'b0;
    end else begin : compare
      resp_t r;
      check1("req_ready", bus.req_ready, pend.size() < Depth);
      check1("busy", bus.busy, !engine_free || pend.size() != 0);
      if (issued_now) check1("issue_valid", bus.inst_valid, 1'b1);
      if (have_cur) begin
        check32("issue_inst", bus.instruction, cur.inst);
        check32("issue_rs1", bus.rs1_data, cur.rs1);
        check32("issue_rs2", bus.rs2_data, cur.rs2);
      end
      if (engine_free) begin
        check1("idle_inst_valid", bus.inst_valid, 1'b0);
        check1("idle_scalar_ready", bus.scalar_pro_ready, 1'b0);
      end
      check1("ready_valid_excl", bus.scalar_pro_ready & bus.inst_valid, 1'b0);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          check32("resp_data", bus.resp_data, r.data);
          check1("resp_illegal", bus.resp_illegal, r.illegal);
          check1("resp_timeout", bus.resp_timeout, r.timeout);
        end
        release_next = 1'b1;
      end else begin
        check32("resp_data_idle", bus.resp_data, 32'd0);
        check1("resp_illegal_idle", bus.resp_illegal, 1'b0);
        check1("resp_timeout_idle", bus.resp_timeout, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check1({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
    check1({tag, "_scalar_ready"}, bus.scalar_pro_ready, 1'b0);
    check1({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check1({tag, "_resp_illegal"}, bus.resp_illegal, 1'b0);
    check1({tag, "_resp_timeout"}, bus.resp_timeout, 1'b0);
    check1({tag, "_busy"}, bus.busy, 1'b0);
    check32({tag, "_instruction"}, bus.instruction, 32'd0);
    check32({tag, "_rs1"}, bus.rs1_data, 32'd0);
    check32({tag, "_rs2"}, bus.rs2_data, 32'd0);
    check32({tag, "_resp_data"}, bus.resp_data, 32'd0);
  endtask

  initial begin
    int seen_resp;
    int seen_issue;
    bus.req_valid       = 1'b0;
    bus.req_instruction = '0;
    bus.req_rs1_data    = '0;
    bus.req_rs2_data    = '0;
    bus.vec_pro_ready   = 1'b0;
    bus.is_vec          = 1'b0;
    bus.vec_pro_ack     = 1'b0;
    bus.csr_out         = '0;

    // Reset values
    #2;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single vset: best case issue, ack two cycles after CHECK
    tick();                                   // N
    push_req(32'h0C0572D7, 32'd100, 32'd0);
    bus.vec_pro_ready = 1'b1;
    bus.is_vec        = 1'b1;
    expect_resp(32'd8, 1'b0, 1'b0);
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    check1("t1_iv_n1", bus.inst_valid, 1'b0);
    tick();                                   // N+2
    check1("t1_iv_n2", bus.inst_valid, 1'b1);
    check32("t1_inst", bus.instruction, 32'h0C0572D7);
    check32("t1_rs1", bus.rs1_data, 32'd100);
    tick();                                   // N+3 CHECK
    check1("t1_iv_n3", bus.inst_valid, 1'b0);
    check1("t1_spr_n3", bus.scalar_pro_ready, 1'b0);
    tick();                                   // N+4 WAIT_ACK
    check1("t1_spr_n4", bus.scalar_pro_ready, 1'b1);
    tick();                                   // N+5
    bus.vec_pro_ack = 1'b1;
    bus.csr_out     = 32'd8;
    tick();                                   // N+6 RESP
    bus.vec_pro_ack = 1'b0;
    bus.csr_out     = 32'd0;
    check1("t1_rv_n6", bus.resp_valid, 1'b1);
    check32("t1_rdata_n6", bus.resp_data, 32'd8);
    check1("t1_ill_n6", bus.resp_illegal, 1'b0);
    check1("t1_tmo_n6", bus.resp_timeout, 1'b0);
    tick();                                   // N+7
    check1("t1_rv_n7", bus.resp_valid, 1'b0);
    check32("t1_rdata_n7", bus.resp_data, 32'd0);
    check32("t1_inst_kept", bus.instruction, 32'h0C0572D7);

    // Delayed ready, with a stray ack during SEND that must be ignored
    tick();                                   // M
    push_req(32'h02208057, 32'd1, 32'd2);
    bus.vec_pro_ready = 1'b0;
    expect_resp(32'd5, 1'b0, 1'b0);
    tick();                                   // M+1
    bus.req_valid = 1'b0;
    tick();                                   // M+2
    for (int i = 0; i < 5; i++) begin
      bus.vec_pro_ack = (i == 1);
      bus.csr_out     = (i == 1) ? 32'd77 : 32'd0;
      check1("t2_iv_held", bus.inst_valid, 1'b1);
      check32("t2_inst_held", bus.instruction, 32'h02208057);
      tick();
    end
    bus.vec_pro_ready = 1'b1;                 // M+7: transfer
    check1("t2_iv_m7", bus.inst_valid, 1'b1);
    tick();                                   // M+8 CHECK
    bus.vec_pro_ready = 1'b0;
    check1("t2_iv_m8", bus.inst_valid, 1'b0);
    tick();                                   // M+9 WAIT_ACK
    check1("t2_spr_m9", bus.scalar_pro_ready, 1'b1);
    bus.vec_pro_ack = 1'b1;
    bus.csr_out     = 32'd5;
    tick();                                   // M+10 RESP
    bus.vec_pro_ack = 1'b0;
    bus.csr_out     = 32'd0;
    check1("t2_rv", bus.resp_valid, 1'b1);
    check32("t2_rdata", bus.resp_data, 32'd5);

    // Illegal instruction
    tick();                                   // P
    push_req(32'hFFFF_FFFF, 32'd3, 32'd4);
    bus.vec_pro_ready = 1'b1;
    bus.is_vec        = 1'b0;
    bus.csr_out       = 32'd123;
    expect_resp(32'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();                                 // P+i
      bus.req_valid = 1'b0;
      check1("t3_spr_never", bus.scalar_pro_ready, 1'b0);
      if (i == 4) begin
        check1("t3_rv", bus.resp_valid, 1'b1);
        check1("t3_ill", bus.resp_illegal, 1'b1);
        check32("t3_rdata", bus.resp_data, 32'd0);
      end
    end
    bus.is_vec  = 1'b1;
    bus.csr_out = 32'd0;

    // Full FIFO: A issues, B and C fill the queue, D is refused
    tick();                                   // Q
    bus.vec_pro_ready = 1'b0;
    push_req(32'hA000_0001, 32'h11, 32'h12);
    expect_resp(32'hA000_0001 ^ AckMask, 1'b0, 1'b0);
    expect_resp(32'hB000_0002 ^ AckMask, 1'b0, 1'b0);
    expect_resp(32'hC000_0003 ^ AckMask, 1'b0, 1'b0);
    check1("t4_rr_q", bus.req_ready, 1'b1);
    tick();                                   // Q+1
    push_req(32'hB000_0002, 32'h21, 32'h22);
    check1("t4_rr_q1", bus.req_ready, 1'b1);
    tick();                                   // Q+2
    push_req(32'hC000_0003, 32'h31, 32'h32);
    check1("t4_rr_q2", bus.req_ready, 1'b1);
    check32("t4_inst_a", bus.instruction, 32'hA000_0001);
    tick();                                   // Q+3
    push_req(32'hD000_0004, 32'h41, 32'h42);
    check1("t4_rr_q3", bus.req_ready, 1'b0);
    tick();                                   // Q+4
    check1("t4_rr_q4", bus.req_ready, 1'b0);
    bus.req_valid     = 1'b0;
    bus.vec_pro_ready = 1'b1;
    auto_ack          = 1'b1;
    drain("t4_drain", 200);
    auto_ack = 1'b0;

    // Timeout in SEND, with a second instruction queued behind it
    tick();                                   // T
    bus.vec_pro_ready = 1'b0;
    push_req(32'h7000_0001, 32'd7, 32'd8);
    expect_resp(32'd0, 1'b0, 1'b1);
    tick();                                   // T+1
    push_req(32'h7000_0002, 32'd9, 32'd10);
    tick();                                   // T+2 entered SEND
    bus.req_valid = 1'b0;
    check1("t5_iv_send", bus.inst_valid, 1'b1);
    for (int i = 3; i <= 17; i++) begin
      tick();
      check1("t5_no_resp_yet", bus.resp_valid, 1'b0);
    end
    tick();                                   // T+18
    check1("t5_rv", bus.resp_valid, 1'b1);
    check1("t5_tmo", bus.resp_timeout, 1'b1);
    check32("t5_rdata", bus.resp_data, 32'd0);
    check1("t5_iv_dropped", bus.inst_valid, 1'b0);
    bus.vec_pro_ready = 1'b1;
    auto_ack          = 1'b1;
    expect_resp(32'h7000_0002 ^ AckMask, 1'b0, 1'b0);
    tick();                                   // T+19 IDLE pops
    check1("t5_iv_t19", bus.inst_valid, 1'b0);
    tick();                                   // T+20
    check1("t5_next_issue", bus.inst_valid, 1'b1);
    check32("t5_next_inst", bus.instruction, 32'h7000_0002);
    drain("t5_drain", 50);
    auto_ack = 1'b0;

    // Timeout while waiting for the ack
    tick();
    push_req(32'h8000_0001, 32'd1, 32'd1);
    bus.vec_pro_ready = 1'b1;
    expect_resp(32'd0, 1'b0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    drain("t5b_drain", 40);

    // Reset in WAIT_ACK with one entry queued
    tick();                                   // R
    push_req(32'h9000_0001, 32'd1, 32'd2);
    tick();                                   // R+1
    push_req(32'h9000_0002, 32'd3, 32'd4);
    tick();                                   // R+2
    bus.req_valid = 1'b0;
    tick();                                   // R+3
    tick();                                   // R+4 WAIT_ACK
    check1("t6_spr_before", bus.scalar_pro_ready, 1'b1);
    check1("t6_busy_before", bus.busy, 1'b1);
    check1("t6_rr_before", bus.req_ready, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    seen_resp  = 0;
    seen_issue = 0;
    for (int i = 0; i < 12; i++) begin
      bus.vec_pro_ack = (i == 2);
      bus.csr_out     = (i == 2) ? 32'd99 : 32'd0;
      tick();
      if (bus.resp_valid) seen_resp++;
      if (bus.inst_valid) seen_issue++;
    end
    check32("t6_no_resp_after", 32'(seen_resp), 32'd0);
    check32("t6_no_issue_after", 32'(seen_issue), 32'd0);

    // Recovery after reset
    tick();
    push_req(32'h0C0572D7, 32'd16, 32'd0);
    auto_ack = 1'b1;
    expect_resp(32'h0C0572D7 ^ AckMask, 1'b0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    drain("t7_drain", 30);
    auto_ack = 1'b0;
    tick();
    check1("t7_idle_busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
